// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl : in-order dual-issue stage behind the ID issue buffer.
//
// Each cycle the two buffer-head instructions (slot a = oldest, slot b) are
// checked against a small scoreboard (one pending load destination and one
// in-flight divide destination) and against each other. Zero, one (a) or two
// (a+b) instructions issue; the count goes back to the buffer on o_usingNUM
// and the issued instructions are registered into the lane-A/lane-B EX regs.
//
// Handshake: o_usingNUM is the "ready" answer to i_is_valid. Whatever count
// it shows in a cycle is consumed by the buffer at the next rising edge, and
// those instructions appear on o_lane_a/o_lane_b from that edge on.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   i_PC_set1/2     slot a / slot b instruction
//   i_is_valid      [1] slot a valid, [0] slot b valid
//   flush_BR        branch mispredict flush (drops lanes and scoreboard)
//   stall_DCache    DCache miss stall (lanes hold, divider keeps counting)
//   o_usingNUM      combinational issue count: 0, 1 or 2
//   o_lane_a/b      registered EX inputs, o_valid marks a live instruction
//   o_div_busy      registered: divide in flight
// -----------------------------------------------------------------------------
package issue_pkg;
  typedef struct packed {
    logic        o_valid;
    logic [31:0] pc;
    logic [2:0]  inst_type;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [4:0]  rf_rd;
    logic        rf_we;
    logic        mem_we;
  } PC_set;
endpackage

module issue_ctrl
  import issue_pkg::*;
#(
  parameter int DIV_LAT = 8,
  parameter int BIT_MEM = 0,
  parameter int BIT_BR  = 1,
  parameter int BIT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  PC_set       i_PC_set1,
  input  PC_set       i_PC_set2,
  input  logic [1:0]  i_is_valid,
  input  logic        flush_BR,
  input  logic        stall_DCache,
  output logic [1:0]  o_usingNUM,
  output PC_set       o_lane_a,
  output PC_set       o_lane_b,
  output logic        o_div_busy
);

  localparam int CW = $clog2(DIV_LAT) + 1;
  localparam logic [CW-1:0] DIV_START = CW'(DIV_LAT - 1);

  // Scoreboard and lane registers
  PC_set          lane_a_q, lane_b_q;
  logic           ld_v_q;
  logic [4:0]     ld_rd_q;
  logic [CW-1:0]  div_cnt_q, div_cnt_d;
  logic [4:0]     div_rd_q;
  logic           div_busy_q;

  // A register index of 0 is "no operand" and never matches.
  function automatic logic reads(input PC_set x, input logic [4:0] r);
    return (r != 5'd0) && ((x.rf_raddr1 == r) || (x.rf_raddr2 == r));
  endfunction

  function automatic logic is_load(input PC_set x);
    return x.inst_type[BIT_MEM] && !x.mem_we;
  endfunction

  logic hzd_a, hzd_b, a_ok, b_ok, pair_ok, can_issue;
  logic issue_a, issue_b;

  always_comb begin
    hzd_a = (ld_v_q && reads(i_PC_set1, ld_rd_q)) ||
            ((div_cnt_q != '0) &&
             (reads(i_PC_set1, div_rd_q) || i_PC_set1.inst_type[BIT_DIV]));
    hzd_b = (ld_v_q && reads(i_PC_set2, ld_rd_q)) ||
            ((div_cnt_q != '0) &&
             (reads(i_PC_set2, div_rd_q) || i_PC_set2.inst_type[BIT_DIV]));

    // Intra-pair restrictions for dual issue.
    pair_ok = !(i_PC_set1.rf_we && reads(i_PC_set2, i_PC_set1.rf_rd)) &&
              !(i_PC_set1.rf_we && i_PC_set2.rf_we &&
                (i_PC_set1.rf_rd != 5'd0) &&
                (i_PC_set1.rf_rd == i_PC_set2.rf_rd)) &&
              !(i_PC_set1.inst_type[BIT_MEM] && i_PC_set2.inst_type[BIT_MEM]) &&
              !i_PC_set1.inst_type[BIT_BR] &&
              !i_PC_set2.inst_type[BIT_DIV];

    a_ok = i_is_valid[1] && !hzd_a;
    b_ok = a_ok && i_is_valid[0] && !hzd_b && pair_ok;

    can_issue = !rst && !flush_BR && !stall_DCache;
    issue_a   = can_issue && a_ok;
    issue_b   = can_issue && b_ok;

    o_usingNUM = issue_b ? 2'b10 : (issue_a ? 2'b01 : 2'b00);

    // Divider countdown runs regardless of stall; a new divide reloads it.
    if (issue_a && i_PC_set1.inst_type[BIT_DIV]) begin
      div_cnt_d = DIV_START;
    end else if (div_cnt_q != '0) begin
      div_cnt_d = div_cnt_q - CW'(1);
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_a_q   <= '0;
      lane_b_q   <= '0;
      ld_v_q     <= 1'b0;
      ld_rd_q    <= 5'd0;
      div_cnt_q  <= '0;
      div_rd_q   <= 5'd0;
      div_busy_q <= 1'b0;
    end else if (flush_BR) begin
      lane_a_q   <= '0;
      lane_b_q   <= '0;
      ld_v_q     <= 1'b0;
      div_cnt_q  <= '0;
      div_busy_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      div_busy_q <= (div_cnt_d != '0);
      if (!stall_DCache) begin
        if (issue_a) begin
          lane_a_q         <= i_PC_set1;
          lane_a_q.o_valid <= 1'b1;
        end else begin
          lane_a_q <= '0;
        end
        if (issue_b) begin
          lane_b_q         <= i_PC_set2;
          lane_b_q.o_valid <= 1'b1;
        end else begin
          lane_b_q <= '0;
        end
        if (issue_a && i_PC_set1.inst_type[BIT_DIV]) begin
          div_rd_q <= i_PC_set1.rf_rd;
        end
        // Two mem ops never pair, so at most one of these loads is live.
        if (issue_a && is_load(i_PC_set1) && i_PC_set1.rf_we &&
            (i_PC_set1.rf_rd != 5'd0)) begin
          ld_v_q  <= 1'b1;
          ld_rd_q <= i_PC_set1.rf_rd;
        end else if (issue_b && is_load(i_PC_set2) && i_PC_set2.rf_we &&
                     (i_PC_set2.rf_rd != 5'd0)) begin
          ld_v_q  <= 1'b1;
          ld_rd_q <= i_PC_set2.rf_rd;
        end else begin
          ld_v_q <= 1'b0;
        end
      end
    end
  end

  assign o_lane_a   = lane_a_q;
  assign o_lane_b   = lane_b_q;
  assign o_div_busy = div_busy_q;

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
  import issue_pkg::*;

  localparam int DIV_LAT = 8;
  localparam logic [2:0] T_ALU = 3'b000;
  localparam logic [2:0] T_MEM = 3'b001;
  localparam logic [2:0] T_BR  = 3'b010;
  localparam logic [2:0] T_DIV = 3'b100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  PC_set      set1, set2;
  logic [1:0] is_valid;
  logic       flush, stall;
  logic [1:0] using_num;
  PC_set      lane_a, lane_b;
  logic       div_busy;

  issue_ctrl #(.DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_PC_set1(set1), .i_PC_set2(set2), .i_is_valid(is_valid),
    .flush_BR(flush), .stall_DCache(stall),
    .o_usingNUM(using_num), .o_lane_a(lane_a), .o_lane_b(lane_b),
    .o_div_busy(div_busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0] last_num;
  logic [63:0] exp_q[$];   // expected values awaiting comparison

  bit         m_ld_v;
  int         m_ld_rd;
  int         m_div_left;  // cycles of divider occupancy still pending
  int         m_div_rd;
  PC_set      m_lane_a, m_lane_b;

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] expv;
    expv = exp_q.pop_front();
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit uses(PC_set x, int r);
    return r != 0 && (int'(x.rf_raddr1) == r || int'(x.rf_raddr2) == r);
  endfunction

  function automatic bit blocked(PC_set x);
    if (m_ld_v && uses(x, m_ld_rd)) return 1;
    if (m_div_left > 0 && (uses(x, m_div_rd) || x.inst_type[2])) return 1;
    return 0;
  endfunction

  function automatic int model_num();
    bit a_ok, b_ok;
    if (rst || flush || stall) return 0;
    a_ok = is_valid[1] && !blocked(set1);
    b_ok = a_ok && is_valid[0] && !blocked(set2);
    if (set1.rf_we && uses(set2, int'(set1.rf_rd))) b_ok = 0;
    if (set1.rf_we && set2.rf_we && set1.rf_rd != 0 && set1.rf_rd == set2.rf_rd) b_ok = 0;
    if (set1.inst_type[0] && set2.inst_type[0]) b_ok = 0;
    if (set1.inst_type[1] || set2.inst_type[2]) b_ok = 0;
    return b_ok ? 2 : (a_ok ? 1 : 0);
  endfunction

  function automatic bit makes_ld(PC_set x);
    return x.inst_type[0] && !x.mem_we && x.rf_we && x.rf_rd != 0;
  endfunction

  // Advance the model by one clock edge using the pre-edge inputs.
  task automatic model_edge(input int n);
    if (rst) begin
      m_ld_v = 0; m_ld_rd = 0; m_div_left = 0; m_div_rd = 0;
      m_lane_a = '0; m_lane_b = '0;
    end else if (flush) begin
      m_ld_v = 0; m_div_left = 0; m_lane_a = '0; m_lane_b = '0;
    end else if (stall) begin
      if (m_div_left > 0) m_div_left--;
    end else begin
      m_lane_a = '0; m_lane_b = '0;
      if (n >= 1) begin m_lane_a = set1; m_lane_a.o_valid = 1'b1; end
      if (n == 2) begin m_lane_b = set2; m_lane_b.o_valid = 1'b1; end
      m_ld_v = 0;
      if (n >= 1 && makes_ld(set1)) begin m_ld_v = 1; m_ld_rd = int'(set1.rf_rd); end
      if (n == 2 && makes_ld(set2)) begin m_ld_v = 1; m_ld_rd = int'(set2.rf_rd); end
      if (n >= 1 && set1.inst_type[2]) begin
        m_div_left = DIV_LAT - 1; m_div_rd = int'(set1.rf_rd);
      end else if (m_div_left > 0) begin
        m_div_left--;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic PC_set mk(logic [2:0] t, int rd, int r1, int r2, bit we, bit mwe);
    PC_set s;
    s = '0;
    s.o_valid = 1'b0;
    s.pc = $urandom;
    s.inst_type = t;
    s.rf_rd = 5'(rd); s.rf_raddr1 = 5'(r1); s.rf_raddr2 = 5'(r2);
    s.rf_we = we; s.mem_we = mwe;
    return s;
  endfunction

  function automatic PC_set rnd_inst();
    int k;
    logic [2:0] t;
    k = $urandom_range(0, 99);
    t = (k < 25) ? T_MEM : (k < 40) ? T_BR : (k < 50) ? T_DIV : T_ALU;
    return mk(t, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1, (t == T_MEM) && $urandom_range(0, 1) == 1);
  endfunction

  // One cycle: inputs already applied at the falling edge.
  task automatic step(input string tag);
    int n;
    #1;
    n = model_num();
    exp_q.push_back(64'(n));
    last_num = using_num;
    chk({tag, "_num"}, 64'(using_num));
    @(posedge clk);
    model_edge(n);
    #1;
    exp_q.push_back(64'(m_lane_a));
    chk({tag, "_lane_a"}, 64'(lane_a));
    exp_q.push_back(64'(m_lane_b));
    chk({tag, "_lane_b"}, 64'(lane_b));
    exp_q.push_back(64'(m_div_left != 0));
    chk({tag, "_busy"}, 64'(div_busy));
    @(negedge clk);
  endtask

  task automatic expect_num(input string tag, input int v);
    exp_q.push_back(64'(v));
    chk(tag, 64'(last_num));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    set1 = '0; set2 = '0; is_valid = 2'b00; flush = 0; stall = 0;
    m_ld_v = 0; m_ld_rd = 0; m_div_left = 0; m_div_rd = 0;
    m_lane_a = '0; m_lane_b = '0;
    @(negedge clk);
    rst = 1; is_valid = 2'b11;
    step("reset"); step("reset");
    expect_num("reset_num0", 0);
    rst = 0;

    // independent add pair
    set1 = mk(T_ALU, 1, 2, 3, 1, 0); set2 = mk(T_ALU, 4, 5, 6, 1, 0); is_valid = 2'b11;
    step("pair"); expect_num("pair_dual", 2);
    exp_q.push_back(64'b11); chk("pair_valids", 64'({lane_a.o_valid, lane_b.o_valid}));

    // load-use
    set1 = mk(T_MEM, 5, 2, 0, 1, 0); set2 = mk(T_ALU, 6, 5, 1, 1, 0);
    step("ld_raw"); expect_num("ld_raw_one", 1);
    set1 = set2; is_valid = 2'b10;
    step("ld_use"); expect_num("ld_use_zero", 0);
    step("ld_after"); expect_num("ld_after_one", 1);

    // divide then a reader of r7 waits for the divider
    set1 = mk(T_DIV, 7, 1, 2, 1, 0); is_valid = 2'b10;
    step("div");
    set1 = mk(T_ALU, 8, 7, 0, 1, 0);
    for (int i = 0; i < DIV_LAT - 1; i++) step("div_wait");
    expect_num("div_rd_block", 0);
    step("div_done"); expect_num("div_reader_go", 1);

    // second divide waits too
    set1 = mk(T_DIV, 9, 1, 2, 1, 0);
    step("div2_a");
    for (int i = 0; i < DIV_LAT; i++) step("div2_b");
    expect_num("div2_issue", 1);
    set1 = mk(T_ALU, 3, 1, 2, 1, 0);
    for (int i = 0; i < DIV_LAT; i++) step("drain");

    // pair restrictions
    is_valid = 2'b11;
    set1 = mk(T_BR, 0, 1, 2, 0, 0); set2 = mk(T_ALU, 4, 5, 6, 1, 0);
    step("br_a"); expect_num("br_a_one", 1);
    set1 = mk(T_MEM, 0, 1, 2, 0, 1); set2 = mk(T_MEM, 0, 3, 4, 0, 1);
    step("two_st"); expect_num("two_st_one", 1);
    set1 = mk(T_ALU, 6, 1, 2, 1, 0); set2 = mk(T_ALU, 6, 3, 4, 1, 0);
    step("waw"); expect_num("waw_one", 1);
    set1 = mk(T_ALU, 0, 1, 2, 1, 0); set2 = mk(T_ALU, 0, 0, 0, 1, 0);
    step("rd0"); expect_num("rd0_dual", 2);

    // stall with a divide in flight
    set1 = mk(T_DIV, 10, 1, 2, 1, 0); set2 = mk(T_ALU, 11, 1, 2, 1, 0);
    step("div_st");
    set1 = mk(T_ALU, 12, 1, 2, 1, 0); set2 = mk(T_ALU, 13, 1, 2, 1, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) step("stall");
    expect_num("stall_zero", 0);
    stall = 0;

    // flush with pending load and busy divider (stall asserted too)
    set1 = mk(T_MEM, 3, 1, 2, 1, 0); is_valid = 2'b10;
    step("ld_pre");
    flush = 1; stall = 1;
    step("flush");
    exp_q.push_back(64'b0); chk("flush_busy", 64'(div_busy));
    flush = 0; stall = 0;
    set1 = mk(T_ALU, 4, 3, 0, 1, 0);
    step("post_flush"); expect_num("post_flush_go", 1);

    // reset in the middle of a divide
    set1 = mk(T_DIV, 5, 1, 2, 1, 0);
    step("div_rst"); step("div_rst");
    rst = 1;
    step("rst_mid");
    exp_q.push_back(64'b0); chk("rst_mid_all", 64'({lane_a.o_valid, lane_b.o_valid, div_busy}));
    rst = 0;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      set1 = rnd_inst(); set2 = rnd_inst();
      case ($urandom_range(0, 3))
        0: is_valid = 2'b00;
        1: is_valid = 2'b10;
        default: is_valid = 2'b11;
      endcase
      flush = ($urandom_range(0, 29) == 0);
      stall = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    rst = 0; flush = 0; stall = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
